// File: rtl/decodificador_servo.sv
// decodificador_servo
//   Receive-side decoder for a servo PWM line. Measures the high time of each
//   pulse in clock cycles and maps it back to the 2-bit position code.
//   A long low gap reports code 00 (no pulse); a line stuck high reports erro.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous, active-high
//   pwm             asynchronous PWM input
//   posicao[1:0]    last decoded position code
//   valido          posicao reflects a classified pulse or the no-pulse condition
//   largura_medida  high time of the last completed pulse, in cycles
//   erro            last pulse matched no code, or line stuck high
//   db_estado[1:0]  FSM state for debug
//
// Build option: DECODIFICADOR_SERVO_FILTRO_EN adds a 3-sample glitch filter
// after the synchronizer (edge latency +2 cycles, widths unchanged).
//
// state  | meaning
// OCIOSO | idle after reset or stuck-high; waiting for a rise
// ALTO   | line high, width counter running
// BAIXO  | line low after a measured pulse; waiting for the next rise

module decodificador_servo #(
    parameter int conf_periodo = 1000000,
    parameter int largura_01   = 50000,
    parameter int largura_10   = 75000,
    parameter int largura_11   = 100000,
    parameter int tolerancia   = 2500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pwm,
    output logic [1:0]  posicao,
    output logic        valido,
    output logic [19:0] largura_medida,
    output logic        erro,
    output logic [1:0]  db_estado
);

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        ALTO   = 2'b01,
        BAIXO  = 2'b10
    } estado_t;

    localparam logic [19:0]        LARG_MAX = '1;
    localparam logic [20:0]        GAP_MAX  = '1;
    localparam logic [19:0]        PER_LIM  = 20'(conf_periodo);
    // The gap counter ticks every other cycle, so 2*conf_periodo cycles of
    // silence after a rise correspond to conf_periodo ticks.
    localparam logic [20:0]        GAP_LIM  = 21'(conf_periodo);
    localparam logic signed [20:0] TOL_P    = 21'(tolerancia);
    localparam logic signed [20:0] TOL_N    = -TOL_P;
    localparam logic signed [20:0] NOM_01   = 21'(largura_01);
    localparam logic signed [20:0] NOM_10   = 21'(largura_10);
    localparam logic signed [20:0] NOM_11   = 21'(largura_11);

    estado_t     estado, estado_prox;
    logic        pwm_m, pwm_s2, pwm_s, pwm_d;
    logic        subida, descida;
    logic [19:0] cnt_largura;
    logic [20:0] cnt_gap;
    logic        gap_tick;
    logic        gap_fim;
    logic        ev_pulso, ev_preso, ev_vazio;
    logic        ev_pulso_r, ev_preso_r, ev_vazio_r;
    logic [19:0] largura_cap;
    logic signed [20:0] dif_01, dif_10, dif_11;
    logic        casa_01, casa_10, casa_11;

    // Two-flop synchronizer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_m  <= 1'b0;
            pwm_s2 <= 1'b0;
        end else begin
            pwm_m  <= pwm;
            pwm_s2 <= pwm_m;
        end
    end

`ifdef DECODIFICADOR_SERVO_FILTRO_EN
    logic pwm_f1, pwm_f2, pwm_filt;

    // pwm_s follows the synchronized line only once the current and the two
    // previous synchronized samples agree; otherwise it holds its last value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_f1   <= 1'b0;
            pwm_f2   <= 1'b0;
            pwm_filt <= 1'b0;
        end else begin
            pwm_f1   <= pwm_s2;
            pwm_f2   <= pwm_f1;
            pwm_filt <= pwm_s;
        end
    end

    assign pwm_s = ((pwm_s2 == pwm_f1) && (pwm_f1 == pwm_f2)) ? pwm_s2 : pwm_filt;
`else
    assign pwm_s = pwm_s2;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pwm_d <= 1'b0;
        else       pwm_d <= pwm_s;
    end

    assign subida  =  pwm_s & ~pwm_d;
    assign descida = ~pwm_s &  pwm_d;

    // Width counter: starts at 1 on the rise so a pulse of N cycles reads N.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_largura <= '0;
        end else if (subida) begin
            cnt_largura <= 20'd1;
        end else if (estado == ALTO && cnt_largura != LARG_MAX) begin
            cnt_largura <= cnt_largura + 20'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_gap  <= '0;
            gap_tick <= 1'b0;
        end else if (subida) begin
            cnt_gap  <= '0;
            gap_tick <= 1'b0;
        end else begin
            gap_tick <= ~gap_tick;
            if (gap_tick && cnt_gap != GAP_MAX) cnt_gap <= cnt_gap + 21'd1;
        end
    end

    // True for a single cycle; the counter moves past the limit and saturates,
    // so it cannot fire again before the next rise.
    assign gap_fim = (cnt_gap == GAP_LIM) && !gap_tick;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        ev_pulso    = 1'b0;
        ev_preso    = 1'b0;
        ev_vazio    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (subida)       estado_prox = ALTO;
                else if (gap_fim) ev_vazio    = 1'b1;
            end
            ALTO: begin
                if (descida) begin
                    ev_pulso    = 1'b1;
                    estado_prox = BAIXO;
                end else if (cnt_largura > PER_LIM) begin
                    ev_preso    = 1'b1;
                    estado_prox = OCIOSO;
                end
            end
            BAIXO: begin
                if (subida)       estado_prox = ALTO;
                else if (gap_fim) ev_vazio    = 1'b1;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // Events are registered with the captured width; classification then
    // runs on the stored width and the outputs update one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ev_pulso_r  <= 1'b0;
            ev_preso_r  <= 1'b0;
            ev_vazio_r  <= 1'b0;
            largura_cap <= '0;
        end else begin
            ev_pulso_r <= ev_pulso;
            ev_preso_r <= ev_preso;
            ev_vazio_r <= ev_vazio;
            if (ev_pulso) largura_cap <= cnt_largura;
        end
    end

    // 21-bit signed differences: no wrap-around for any 20-bit width.
    assign dif_01  = $signed({1'b0, largura_cap}) - NOM_01;
    assign dif_10  = $signed({1'b0, largura_cap}) - NOM_10;
    assign dif_11  = $signed({1'b0, largura_cap}) - NOM_11;
    assign casa_01 = (dif_01 <= TOL_P) && (dif_01 >= TOL_N);
    assign casa_10 = (dif_10 <= TOL_P) && (dif_10 >= TOL_N);
    assign casa_11 = (dif_11 <= TOL_P) && (dif_11 >= TOL_N);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            posicao        <= 2'b00;
            valido         <= 1'b0;
            erro           <= 1'b0;
            largura_medida <= '0;
        end else if (ev_pulso_r) begin
            largura_medida <= largura_cap;
            if (casa_01) begin
                posicao <= 2'b01;
                valido  <= 1'b1;
                erro    <= 1'b0;
            end else if (casa_10) begin
                posicao <= 2'b10;
                valido  <= 1'b1;
                erro    <= 1'b0;
            end else if (casa_11) begin
                posicao <= 2'b11;
                valido  <= 1'b1;
                erro    <= 1'b0;
            end else begin
                valido  <= 1'b0;
                erro    <= 1'b1;
            end
        end else if (ev_preso_r) begin
            valido <= 1'b0;
            erro   <= 1'b1;
        end else if (ev_vazio_r) begin
            posicao        <= 2'b00;
            valido         <= 1'b1;
            erro           <= 1'b0;
            largura_medida <= '0;
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_decodificador_servo.sv
// Testbench for decodificador_servo: table-driven pulse widths, randomized
// pulses checked against a width-classification model, and hand-written
// sequences for stuck-high, reset mid-pulse, glitch and no-pulse timeout.

module tb_decodificador_servo;

    localparam int PER = 1000;
    localparam int TOL = 5;
`ifdef DECODIFICADOR_SERVO_FILTRO_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clock;
    logic        reset;
    logic        pwm;
    logic [1:0]  posicao;
    logic        valido;
    logic [19:0] largura_medida;
    logic        erro;
    logic [1:0]  db_estado;

    decodificador_servo #(
        .conf_periodo(PER),
        .largura_01  (50),
        .largura_10  (75),
        .largura_11  (100),
        .tolerancia  (TOL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pwm           (pwm),
        .posicao       (posicao),
        .valido        (valido),
        .largura_medida(largura_medida),
        .erro          (erro),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: what the outputs should currently show
    int m_pos, m_val, m_err, m_larg;

    typedef struct {
        int w;
        int pos;
        int val;
        int err;
    } vec_t;

    vec_t tabela[14];

    task automatic chk(input string nome, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
        end
    endtask

    task automatic chk_saidas(input string tag, input int pos, input int val,
                              input int err, input int larg);
        chk({tag, " posicao"}, int'(posicao), pos);
        chk({tag, " valido"}, int'(valido), val);
        chk({tag, " erro"}, int'(erro), err);
        chk({tag, " largura"}, int'(largura_medida), larg);
    endtask

    // Classify a width: first nominal within tolerance wins, else error and
    // the previous code is kept.
    task automatic modelo_pulso(input int w);
        int nominais[3];
        int d;
        nominais[0] = 50;
        nominais[1] = 75;
        nominais[2] = 100;
        m_larg = w;
        m_val  = 0;
        m_err  = 1;
        for (int i = 0; i < 3; i++) begin
            d = w - nominais[i];
            if (d < 0) d = -d;
            if (m_val == 0 && d <= TOL) begin
                m_pos = i + 1;
                m_val = 1;
                m_err = 0;
            end
        end
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge. Drives a high pulse of w sampled cycles, then
    // checks the previous width is still shown LAT cycles after the fall and
    // returns one cycle later, when the new result must be visible.
    task automatic pulso(input int w, input int larg_antiga);
        pwm = 1'b1;
        for (int i = 0; i < w; i++) begin
            @(negedge clock);
            if (i == w - 1 && w > LAT) chk("db_alto", int'(db_estado), 1);
        end
        pwm = 1'b0;
        espera(LAT);
        if (w != larg_antiga) chk("lat_hold", int'(largura_medida), larg_antiga);
        @(negedge clock);
    endtask

    int w_r, gap_r, j_evt, n_evt;
    bit cond, cond_ant;

    initial begin
        tabela[0]  = '{75, 2, 1, 0};
        tabela[1]  = '{50, 1, 1, 0};
        tabela[2]  = '{104, 3, 1, 0};
        tabela[3]  = '{45, 1, 1, 0};
        tabela[4]  = '{100, 3, 1, 0};
        tabela[5]  = '{62, 3, 0, 1};
        tabela[6]  = '{80, 2, 1, 0};
        tabela[7]  = '{56, 2, 0, 1};
        tabela[8]  = '{70, 2, 1, 0};
        tabela[9]  = '{55, 1, 1, 0};
        tabela[10] = '{95, 3, 1, 0};
        tabela[11] = '{106, 3, 0, 1};
        tabela[12] = '{44, 3, 0, 1};
        tabela[13] = '{105, 3, 1, 0};

        reset = 1'b1;
        pwm   = 1'b0;
        espera(3);
        chk_saidas("reset", 0, 0, 0, 0);
        chk("reset db", int'(db_estado), 0);
        reset = 1'b0;
        espera(5);
        chk_saidas("pos_reset", 0, 0, 0, 0);

        // table-driven pulses, period 1000
        m_larg = 0;
        for (int i = 0; i < 14; i++) begin
            pulso(tabela[i].w, m_larg);
            chk_saidas($sformatf("tab%0d", i), tabela[i].pos, tabela[i].val,
                       tabela[i].err, tabela[i].w);
            m_larg = tabela[i].w;
            espera(PER - tabela[i].w - LAT - 1 - 1);
            chk("db_baixo", int'(db_estado), 2);
        end
        m_pos = 3;
        m_val = 1;
        m_err = 0;

        // randomized widths and gaps against the model
        for (int i = 0; i < 40; i++) begin
            w_r   = int'($urandom_range(112, 40));
            gap_r = int'($urandom_range(800, 20));
            pulso(w_r, m_larg);
            modelo_pulso(w_r);
            chk_saidas($sformatf("rnd%0d_w%0d", i, w_r), m_pos, m_val, m_err, m_larg);
            espera(gap_r);
        end

        // stuck high: timeout after more than PER cycles high
        pwm = 1'b1;
        espera(1100);
        m_val = 0;
        m_err = 1;
        chk_saidas("preso", m_pos, m_val, m_err, m_larg);
        chk("preso db", int'(db_estado), 0);
        pwm = 1'b0;
        espera(150);
        chk("preso db_baixo", int'(db_estado), 0);
        chk_saidas("preso fall", m_pos, m_val, m_err, m_larg);
        pulso(100, m_larg);
        modelo_pulso(100);
        chk_saidas("pos_preso", 3, 1, 0, 100);
        espera(300);

        // reset 30 cycles into a 100-cycle pulse
        pwm = 1'b1;
        espera(30);
        reset = 1'b1;
        #1;
        chk_saidas("rst_meio", 0, 0, 0, 0);
        chk("rst_meio db", int'(db_estado), 0);
        espera(70);
        pwm = 1'b0;
        espera(10);
        reset = 1'b0;
        espera(20);
        m_pos = 0; m_val = 0; m_err = 0; m_larg = 0;
        chk_saidas("rst_solto", m_pos, m_val, m_err, m_larg);
        pulso(100, m_larg);
        modelo_pulso(100);
        chk_saidas("pos_rst", 3, 1, 0, 100);
        espera(200);

        // 1-cycle glitch in the low gap
        pulso(75, m_larg);
        modelo_pulso(75);
        chk_saidas("pre_glitch", 2, 1, 0, 75);
        espera(100);
        pwm = 1'b1;
        @(negedge clock);
        pwm = 1'b0;
        espera(LAT + 3);
`ifndef DECODIFICADOR_SERVO_FILTRO_EN
        modelo_pulso(1);
`endif
        chk_saidas("glitch", m_pos, m_val, m_err, m_larg);
        chk("glitch db", int'(db_estado), 2);
        espera(200);

        // no pulse: long low after a valid pulse reports code 00 exactly once
        pulso(75, m_larg);
        modelo_pulso(75);
        chk_saidas("pre_vazio", 2, 1, 0, 75);
        n_evt    = 0;
        j_evt    = -1;
        cond_ant = 1'b0;
        // j counts negedges after the fall was driven; LAT+1 already elapsed
        for (int j = LAT + 2; j <= 2600; j++) begin
            @(negedge clock);
            cond = (posicao == 2'b00) && valido && (largura_medida == 20'd0);
            if (cond && !cond_ant) begin
                n_evt++;
                if (j_evt < 0) j_evt = j;
            end
            cond_ant = cond;
        end
        chk("vazio contagem", n_evt, 1);
        chk("vazio janela", int'(j_evt >= 1920 && j_evt <= 1940), 1);
        chk_saidas("vazio", 0, 1, 0, 0);
        chk("vazio db", int'(db_estado), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
